pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and next-PC stage for the RV32I core, directly downstream of the branch comparator. It consumes the comparator's equal/less-than flags together with decode control, resolves conditional branches, JAL and JALR, and holds the architectural PC. It also drives the instruction-fetch request handshake and raises a one-cycle trap on a misaligned control-flow target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TRAP_PC, 32'h0000_0100: PC loaded on a misaligned-target trap.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- if_ready  input  1  instruction memory accepts the current fetch request.
- exec_done  input  1  decode/execute has finished; control inputs are valid this cycle.
- stall  input  1  holds the commit in EXEC.
- is_branch, is_jal, is_jalr  input  1 each  decode control; one-hot expected.
- funct3  input  3  instruction funct3.
- BrEq, BrLT  input  1 each  comparator results for rs1/rs2.
- imm  input  32  sign-extended immediate (B/J/I type).
- rs1_data  input  32  base register value for JALR.
- pc_out  output  32  current PC and fetch address.
- pc_plus4  output  32  pc_out + 4, combinational; used as the link value.
- req_valid  output  1  fetch request valid.
- taken  output  1  one-cycle pulse when a control transfer commits.
- misalign  output  1  one-cycle pulse when a misaligned-target trap commits.
- illegal_br  output  1  one-cycle pulse when a branch with funct3 010/011 commits.
- epc  output  32  PC of the most recent trapping instruction.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- Reset: state=IDLE. Outputs: pc_out=RESET_PC, req_valid=0, taken=0, misalign=0, illegal_br=0, epc=0.
- IDLE: moves to FETCH unconditionally on the next edge.
- FETCH: req_valid=1 with pc_out stable. On if_ready=1, move to EXEC.
- EXEC: req_valid=0. A commit occurs when exec_done=1 and stall=0. On commit, update the PC and return to FETCH. Otherwise hold everything.
- Branch condition by funct3:
  - 000: BrEq
  - 001: !BrEq
  - 100/110: BrLT
  - 101/111: !BrLT
  - 010/011: not taken, and illegal_br pulses.
- Target selection, priority jalr > jal > branch:
  - JALR: (rs1_data + imm) & ~32'h1.
  - JAL, or a taken branch: pc_out + imm.
  - Otherwise: pc_plus4.
- All additions are 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Misalign: target[1]=1 on a JAL, JALR or taken branch. Then pc_out<=TRAP_PC, epc<=the faulting pc_out, misalign pulses, and taken stays 0.
- A not-taken branch with a misaligned would-be target does not trap.

## Timing
- Commit at edge N: the new pc_out, the taken/misalign/illegal_br pulses and the state change all become visible after edge N. Pulses last exactly one cycle.
- Minimum instruction period is 2 cycles: FETCH with immediate if_ready, then EXEC with immediate exec_done.
- exec_done is ignored outside EXEC. if_ready is ignored outside FETCH.
- stall=1 with exec_done=1 holds EXEC. The commit happens on the first cycle where stall=0, using the control inputs of that cycle.
- rst asserted in any state, including mid-FETCH with if_ready=1, wins: the reset values apply after that edge.

## Structure
- Shared package rv32i_pkg holds:
  - the funct3 branch encodings (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - the pc_unit state enum;
  - the default RESET_PC/TRAP_PC constants.
- Sub-module branch_resolve: combinational; takes funct3, BrEq and BrLT; produces br_cond and br_illegal.
- pc_unit contains the FSM, target adders, misalign check and registers.

## Test plan
- Reset then fetch: assert rst 2 cycles, then release. Expect pc_out=0 and req_valid=0 in IDLE, then req_valid=1 the next cycle. if_ready=1 moves to EXEC.
- BEQ taken: pc=0x40, funct3=000, BrEq=1, imm=0x20, exec_done=1. Expect pc_out=0x60 and taken=1 for one cycle. Repeat with BrEq=0: expect pc_out=0x44, taken=0.
- BGEU/BLT: funct3=111, BrLT=0, imm=-8 at pc=0x100 -> 0xF8. funct3=100, BrLT=0 -> 0x104.
- JALR masking and misalign: rs1=0x1001, imm=0 -> pc_out=0x1000, taken=1. rs1=0x1002 -> pc_out=TRAP_PC, misalign=1, epc=faulting PC.
- Stall and illegal: exec_done=1 with stall=1 for 3 cycles -> pc_out unchanged. Release -> commit. funct3=010 branch -> pc+4 and illegal_br=1.
- Reset mid-EXEC with exec_done=1 and a taken JAL -> pc_out=RESET_PC, taken=0, state IDLE.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I encodings, pc_unit state type and default PCs
package rv32i_pkg;

    // Branch funct3 encodings; 010 and 011 are not valid branches.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch condition decode from funct3 and comparator flags
module branch_resolve
    import rv32i_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       BrEq,
    input  logic       BrLT,
    output logic       br_cond,
    output logic       br_illegal
);

    // Signed and unsigned compares share BrLT; the comparator already picked the mode.
    always_comb begin
        br_cond    = 1'b0;
        br_illegal = 1'b0;
        case (funct3)
            F3_BEQ:            br_cond = BrEq;
            F3_BNE:            br_cond = ~BrEq;
            F3_BLT, F3_BLTU:   br_cond = BrLT;
            F3_BGE, F3_BGEU:   br_cond = ~BrLT;
            default:           br_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter, next-PC selection, fetch handshake and misalign trap
module pc_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ready,
    input  logic        exec_done,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic        BrEq,
    input  logic        BrLT,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        req_valid,
    output logic        taken,
    output logic        misalign,
    output logic        illegal_br,
    output logic [31:0] epc
);

    pc_state_t   state;
    logic        br_cond;
    logic        br_illegal;
    logic        branch_sel;
    logic        transfer;
    logic        bad_target;
    logic        commit;
    logic [31:0] jalr_target;
    logic [31:0] rel_target;
    logic [31:0] target;

    branch_resolve u_branch_resolve (
        .funct3     (funct3),
        .BrEq       (BrEq),
        .BrLT       (BrLT),
        .br_cond    (br_cond),
        .br_illegal (br_illegal)
    );

    assign pc_plus4    = pc_out + 32'd4;
    assign jalr_target = (rs1_data + imm) & 32'hFFFF_FFFE;
    assign rel_target  = pc_out + imm;
    assign req_valid   = (state == ST_FETCH);
    assign commit      = (state == ST_EXEC) && exec_done && !stall;

    // Next-PC select with jalr > jal > branch priority; only real transfers can trap.
    always_comb begin
        branch_sel = is_branch & ~is_jal & ~is_jalr;
        transfer   = is_jalr | is_jal | (branch_sel & br_cond);
        if (is_jalr)
            target = jalr_target;
        else if (transfer)
            target = rel_target;
        else
            target = pc_plus4;
        bad_target = transfer & target[1];
    end

    // FSM, PC/EPC registers and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc_out     <= RESET_PC;
            epc        <= 32'h0;
            taken      <= 1'b0;
            misalign   <= 1'b0;
            illegal_br <= 1'b0;
        end else begin
            taken      <= 1'b0;
            misalign   <= 1'b0;
            illegal_br <= 1'b0;
            case (state)
                ST_IDLE:  state <= ST_FETCH;
                ST_FETCH: if (if_ready) state <= ST_EXEC;
                ST_EXEC: begin
                    if (commit) begin
                        state      <= ST_FETCH;
                        illegal_br <= branch_sel & br_illegal;
                        if (bad_target) begin
                            pc_out   <= TRAP_PC;
                            epc      <= pc_out;
                            misalign <= 1'b1;
                        end else begin
                            pc_out <= target;
                            taken  <= transfer;
                        end
                    end
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed and randomized self-checking bench for pc_unit
module tb_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRP_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, if_ready, exec_done, stall;
    logic        is_branch, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic        BrEq, BrLT;
    logic [31:0] imm, rs1_data;
    logic [31:0] pc_out, pc_plus4, epc;
    logic        req_valid, taken, misalign, illegal_br;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 waiting for fetch accept, 2 waiting for execute
    int          m_phase;
    logic [31:0] m_pc, m_epc;
    logic        m_taken, m_mis, m_ill;

    always #5 clk = ~clk;

    pc_unit #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
        .clk(clk), .rst(rst), .if_ready(if_ready), .exec_done(exec_done), .stall(stall),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
        .BrEq(BrEq), .BrLT(BrLT), .imm(imm), .rs1_data(rs1_data),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .req_valid(req_valid), .taken(taken),
        .misalign(misalign), .illegal_br(illegal_br), .epc(epc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit          cond, xfer;
        logic [31:0] tgt;
        m_taken = 0; m_mis = 0; m_ill = 0;
        if (rst) begin
            m_phase = 0; m_pc = RST_PC; m_epc = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (if_ready) m_phase = 2;
        end else if (exec_done && !stall) begin
            m_phase = 1;
            cond = 0;
            if (funct3 == 3'd0)      cond = BrEq;
            else if (funct3 == 3'd1) cond = !BrEq;
            else if (funct3 == 3'd4 || funct3 == 3'd6) cond = BrLT;
            else if (funct3 == 3'd5 || funct3 == 3'd7) cond = !BrLT;
            if (is_jalr)      begin xfer = 1; tgt = (rs1_data + imm) & ~32'h1; end
            else if (is_jal)  begin xfer = 1; tgt = m_pc + imm; end
            else if (is_branch && cond) begin xfer = 1; tgt = m_pc + imm; end
            else              begin xfer = 0; tgt = m_pc + 4; end
            m_ill = is_branch && !is_jal && !is_jalr && (funct3 == 3'd2 || funct3 == 3'd3);
            if (xfer && tgt[1]) begin
                m_epc = m_pc; m_pc = TRP_PC; m_mis = 1;
            end else begin
                m_pc = tgt; m_taken = xfer;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc_out, m_pc);
        chk({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, ".req"}, {31'b0, req_valid}, {31'b0, m_phase == 1});
        chk({tag, ".taken"}, {31'b0, taken}, {31'b0, m_taken});
        chk({tag, ".mis"}, {31'b0, misalign}, {31'b0, m_mis});
        chk({tag, ".ill"}, {31'b0, illegal_br}, {31'b0, m_ill});
        chk({tag, ".epc"}, epc, m_epc);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    task automatic ctrl(input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                        input bit eq, input bit lt, input logic [31:0] im, input logic [31:0] r1);
        is_branch = br; is_jal = jal; is_jalr = jalr; funct3 = f3;
        BrEq = eq; BrLT = lt; imm = im; rs1_data = r1;
    endtask

    // one instruction from FETCH: immediate accept, then immediate commit
    task automatic instr(input string tag, input bit br, input bit jal, input bit jalr,
                         input logic [2:0] f3, input bit eq, input bit lt,
                         input logic [31:0] im, input logic [31:0] r1);
        if_ready = 1; exec_done = 0; stall = 0;
        cyc({tag, ".f"});
        if_ready = 0; exec_done = 1;
        ctrl(br, jal, jalr, f3, eq, lt, im, r1);
        cyc({tag, ".x"});
        exec_done = 0;
        ctrl(0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1; if_ready = 0; exec_done = 0; stall = 0;
        ctrl(0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0);
        m_phase = 0; m_pc = RST_PC; m_epc = 0; m_taken = 0; m_mis = 0; m_ill = 0;

        cyc("rst0");
        cyc("rst1");
        chk("reset_pc_const", pc_out, 32'h0);
        chk("reset_req_const", {31'b0, req_valid}, 32'h0);
        rst = 0;
        cyc("idle");
        chk("fetch_req_const", {31'b0, req_valid}, 32'h1);

        instr("jal40", 0, 1, 0, 3'd0, 0, 0, 32'h40, 32'h0);
        chk("jal40_pc", pc_out, 32'h40);
        instr("beq_t", 1, 0, 0, 3'd0, 1, 0, 32'h20, 32'h0);
        chk("beq_t_pc", pc_out, 32'h60);
        chk("beq_t_taken", {31'b0, taken}, 32'h1);
        instr("jal_back", 0, 1, 0, 3'd0, 0, 0, 32'hFFFF_FFE0, 32'h0);
        instr("beq_nt", 1, 0, 0, 3'd0, 0, 0, 32'h20, 32'h0);
        chk("beq_nt_pc", pc_out, 32'h44);
        chk("beq_nt_taken", {31'b0, taken}, 32'h0);

        instr("jal100", 0, 0, 1, 3'd0, 0, 0, 32'h0, 32'h100);
        instr("bgeu", 1, 0, 0, 3'd7, 0, 0, 32'hFFFF_FFF8, 32'h0);
        chk("bgeu_pc", pc_out, 32'hF8);
        instr("blt_nt", 1, 0, 0, 3'd4, 0, 0, 32'h40, 32'h0);
        chk("blt_nt_pc", pc_out, 32'hFC);

        instr("jalr_mask", 0, 0, 1, 3'd0, 0, 0, 32'h0, 32'h1001);
        chk("jalr_mask_pc", pc_out, 32'h1000);
        instr("jalr_mis", 0, 0, 1, 3'd0, 0, 0, 32'h0, 32'h1002);
        chk("jalr_mis_pc", pc_out, TRP_PC);
        chk("jalr_mis_epc", epc, 32'h1000);
        chk("jalr_mis_flag", {31'b0, misalign}, 32'h1);
        instr("nt_mis", 1, 0, 0, 3'd1, 1, 0, 32'h2, 32'h0);
        chk("nt_mis_pc", pc_out, TRP_PC + 32'd4);

        // stall holds EXEC for three cycles, then the unstalled cycle's controls commit
        if_ready = 1;
        cyc("st.f");
        if_ready = 0; exec_done = 1; stall = 1;
        ctrl(0, 1, 0, 3'd0, 0, 0, 32'h80, 32'h0);
        cyc("st0"); cyc("st1"); cyc("st2");
        chk("stall_hold_pc", pc_out, TRP_PC + 32'd4);
        stall = 0;
        ctrl(0, 1, 0, 3'd0, 0, 0, 32'h10, 32'h0);
        cyc("st_rel");
        chk("stall_rel_pc", pc_out, TRP_PC + 32'd20);
        exec_done = 0;
        ctrl(0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0);

        instr("ill", 1, 0, 0, 3'd2, 1, 1, 32'h40, 32'h0);
        chk("ill_pc", pc_out, TRP_PC + 32'd24);
        chk("ill_flag", {31'b0, illegal_br}, 32'h1);

        // wrap: 0xFFFF_FFFC + 4 -> 0
        instr("to_top", 0, 0, 1, 3'd0, 0, 0, 32'hFFFF_FFFC, 32'h0);
        instr("wrap", 1, 0, 0, 3'd0, 0, 0, 32'h8, 32'h0);
        chk("wrap_pc", pc_out, 32'h0);

        // reset mid-EXEC with a taken JAL pending
        if_ready = 1;
        cyc("rx.f");
        if_ready = 0; exec_done = 1; rst = 1;
        ctrl(0, 1, 0, 3'd0, 0, 0, 32'h40, 32'h0);
        cyc("rx");
        chk("rx_pc", pc_out, RST_PC);
        chk("rx_taken", {31'b0, taken}, 32'h0);
        rst = 0; exec_done = 0;
        cyc("rx_idle");

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int sel;
            rst       = ($urandom_range(0, 49) == 0);
            if_ready  = $urandom_range(0, 2) != 0;
            exec_done = $urandom_range(0, 2) != 0;
            stall     = $urandom_range(0, 3) == 0;
            sel       = $urandom_range(0, 3);
            is_branch = (sel == 0) || (sel == 1);
            is_jal    = (sel == 2);
            is_jalr   = (sel == 3);
            funct3    = 3'($urandom_range(0, 7));
            BrEq      = 1'($urandom_range(0, 1));
            BrLT      = 1'($urandom_range(0, 1));
            imm       = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 255)) << 2) - 32'h200;
            rs1_data  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1023)) << 2;
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
